// File: rtl/ctl_missile_pl_if.sv
// Signal bundle between the player missile controller and its neighbours
// (player control, missile draw, collision detector, sound/score).
interface ctl_missile_pl_if;
   logic [11:0] xpos_in;
   logic [11:0] ypos_in;
   logic        fire_button;
   logic        hit;
   logic        player_alive;
   logic [11:0] xpos_out;
   logic [11:0] ypos_out;
   logic        on_out;
   logic        shot_fired;

   modport master (
      output xpos_in, ypos_in, fire_button, hit, player_alive,
      input  xpos_out, ypos_out, on_out, shot_fired
   );

   modport slave (
      input  xpos_in, ypos_in, fire_button, hit, player_alive,
      output xpos_out, ypos_out, on_out, shot_fired
   );
endinterface

// File: rtl/ctl_missile_pl.sv
// Player missile controller: launches one upward missile per fire-button edge
// and retires it on hit, top limit or player death, followed by a cooldown.
//
// state    | meaning
// IDLE     | no missile; waiting for a fresh fire edge while player alive
// SHOOT    | one cycle: latch launch position, raise on_out and shot_fired
// FLY      | missile visible, climbs STEP px every COUNTER_LIMIT+1 cycles
// COOLDOWN | missile retired; COOLDOWN_LIMIT+1 cycles before re-arming
module ctl_missile_pl #(
   parameter int COUNTER_LIMIT      = 90000,
   parameter int STEP               = 1,
   parameter int X_OFFSET           = 22,
   parameter int MISSILE_HEIGHT_MIN = 80,
   parameter int COOLDOWN_LIMIT     = 2000000
) (
   input  logic             pclk,
   input  logic             rst_n,
   ctl_missile_pl_if.slave  bus
);

   localparam int REF_W = 17;
   localparam int CD_W  = 21;

   localparam logic [11:0]      STEP_V  = 12'(STEP);
   localparam logic [11:0]      XOFF_V  = 12'(X_OFFSET);
   localparam logic [11:0]      YMIN_V  = 12'(MISSILE_HEIGHT_MIN);
   localparam logic [REF_W-1:0] REF_LIM = REF_W'(COUNTER_LIMIT);
   localparam logic [CD_W-1:0]  CD_LIM  = CD_W'(COOLDOWN_LIMIT);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SHOOT    = 2'd1,
      FLY      = 2'd2,
      COOLDOWN = 2'd3
   } state_t;

   state_t           state, state_nxt;
   logic             fire_d;
   logic             fire_rise;
   logic [11:0]      xpos, xpos_nxt;
   logic [11:0]      ypos, ypos_nxt;
   logic             on, on_nxt;
   logic             shot, shot_nxt;
   logic [REF_W-1:0] ref_cnt, ref_nxt;
   logic [CD_W-1:0]  cd_cnt, cd_nxt;

   // fire_d resets high so a button held through reset never looks like an edge
   assign fire_rise = bus.fire_button & ~fire_d;

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         fire_d  <= 1'b1;
         xpos    <= '0;
         ypos    <= '0;
         on      <= 1'b0;
         shot    <= 1'b0;
         ref_cnt <= '0;
         cd_cnt  <= '0;
      end else begin
         state   <= state_nxt;
         fire_d  <= bus.fire_button;
         xpos    <= xpos_nxt;
         ypos    <= ypos_nxt;
         on      <= on_nxt;
         shot    <= shot_nxt;
         ref_cnt <= ref_nxt;
         cd_cnt  <= cd_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      xpos_nxt  = xpos;
      ypos_nxt  = ypos;
      on_nxt    = 1'b0;
      shot_nxt  = 1'b0;
      ref_nxt   = ref_cnt;
      cd_nxt    = cd_cnt;
      case (state)
         IDLE: begin
            if (fire_rise && bus.player_alive) state_nxt = SHOOT;
         end
         SHOOT: begin
            xpos_nxt  = bus.xpos_in + XOFF_V;
            ypos_nxt  = bus.ypos_in;
            on_nxt    = 1'b1;
            shot_nxt  = 1'b1;
            ref_nxt   = '0;
            state_nxt = FLY;
         end
         FLY: begin
            // retirement wins over a step landing on the same cycle
            if (bus.hit || !bus.player_alive || (ypos <= YMIN_V)) begin
               cd_nxt    = '0;
               state_nxt = COOLDOWN;
            end else begin
               on_nxt = 1'b1;
               if (ref_cnt == REF_LIM) begin
                  ref_nxt  = '0;
                  ypos_nxt = (ypos > YMIN_V + STEP_V) ? ypos - STEP_V : YMIN_V;
               end else begin
                  ref_nxt = ref_cnt + 1'b1;
               end
            end
         end
         COOLDOWN: begin
            if (cd_cnt == CD_LIM) state_nxt = IDLE;
            else                  cd_nxt    = cd_cnt + 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.xpos_out   = xpos;
   assign bus.ypos_out   = ypos;
   assign bus.on_out     = on;
   assign bus.shot_fired = shot;

endmodule

// File: tb/tb_ctl_missile_pl.sv
// Directed bench for ctl_missile_pl with short timers (step every 4 cycles,
// 6-cycle cooldown); expected values are worked out by hand per scenario.
module tb_ctl_missile_pl;

   logic pclk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   ctl_missile_pl_if bus();

   ctl_missile_pl #(
      .COUNTER_LIMIT      (3),
      .STEP               (1),
      .X_OFFSET           (22),
      .MISSILE_HEIGHT_MIN (80),
      .COOLDOWN_LIMIT     (5)
   ) dut (
      .pclk  (pclk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge pclk);
         #1;
      end
   endtask

   // Edge k samples the rise; positions and shot_fired appear after edge k+1.
   task automatic launch(input string tag, input logic [11:0] x, input logic [11:0] y,
                         input logic [11:0] x_exp, input bit hold);
      bus.xpos_in     = x;
      bus.ypos_in     = y;
      bus.fire_button = 1'b1;
      tick(1);
      chk({tag, "_pre_on"}, 32'(bus.on_out), 32'd0);
      tick(1);
      chk({tag, "_on"}, 32'(bus.on_out), 32'd1);
      chk({tag, "_shot"}, 32'(bus.shot_fired), 32'd1);
      chk({tag, "_x"}, 32'(bus.xpos_out), 32'(x_exp));
      chk({tag, "_y"}, 32'(bus.ypos_out), 32'(y));
      if (!hold) bus.fire_button = 1'b0;
   endtask

   initial begin
      n_checks         = 0;
      n_errors         = 0;
      rst_n            = 1'b0;
      bus.xpos_in      = '0;
      bus.ypos_in      = '0;
      bus.fire_button  = 1'b0;
      bus.hit          = 1'b0;
      bus.player_alive = 1'b1;
      #12;
      chk("rst_on", 32'(bus.on_out), 32'd0);
      chk("rst_shot", 32'(bus.shot_fired), 32'd0);
      chk("rst_x", 32'(bus.xpos_out), 32'd0);
      chk("rst_y", 32'(bus.ypos_out), 32'd0);
      rst_n = 1'b1;
      tick(2);

      // 1: launch and climb, then 3: hit on a step cycle, cooldown press ignored
      launch("s1", 12'd100, 12'd600, 12'd122, 1'b0);
      bus.xpos_in = 12'd999;
      bus.ypos_in = 12'd999;
      tick(1);
      chk("s1_shot_drop", 32'(bus.shot_fired), 32'd0);
      chk("s1_x_hold", 32'(bus.xpos_out), 32'd122);
      tick(2);
      chk("s1_y_prestep", 32'(bus.ypos_out), 32'd600);
      tick(1);
      chk("s1_y_step1", 32'(bus.ypos_out), 32'd599);
      tick(4);
      chk("s1_y_step2", 32'(bus.ypos_out), 32'd598);
      tick(3);
      bus.hit = 1'b1;
      tick(1);
      bus.hit = 1'b0;
      chk("s3_hit_on", 32'(bus.on_out), 32'd0);
      chk("s3_hit_y", 32'(bus.ypos_out), 32'd598);
      chk("s3_hit_x", 32'(bus.xpos_out), 32'd122);
      bus.fire_button = 1'b1;
      tick(3);
      bus.fire_button = 1'b0;
      tick(2);
      bus.fire_button = 1'b1;
      tick(1);
      bus.fire_button = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("s3_cd_on", 32'(bus.on_out), 32'd0);
         chk("s3_cd_shot", 32'(bus.shot_fired), 32'd0);
         tick(1);
      end
      launch("s3_re", 12'd200, 12'd300, 12'd222, 1'b0);

      // 5: player death in flight, then a press while dead
      tick(2);
      bus.player_alive = 1'b0;
      tick(1);
      chk("s5_dead_on", 32'(bus.on_out), 32'd0);
      tick(7);
      bus.fire_button = 1'b1;
      tick(3);
      chk("s5_dead_fire_on", 32'(bus.on_out), 32'd0);
      chk("s5_dead_fire_shot", 32'(bus.shot_fired), 32'd0);
      bus.fire_button  = 1'b0;
      bus.player_alive = 1'b1;
      tick(1);

      // 2: top limit saturation, exact cooldown length, relaunch on first IDLE edge
      launch("s2", 12'd10, 12'd82, 12'd32, 1'b0);
      tick(3);
      chk("s2_y82", 32'(bus.ypos_out), 32'd82);
      tick(1);
      chk("s2_y81", 32'(bus.ypos_out), 32'd81);
      tick(4);
      chk("s2_y80", 32'(bus.ypos_out), 32'd80);
      chk("s2_y80_on", 32'(bus.on_out), 32'd1);
      tick(1);
      chk("s2_top_on", 32'(bus.on_out), 32'd0);
      chk("s2_top_y", 32'(bus.ypos_out), 32'd80);
      tick(6);
      launch("s2_re", 12'd4090, 12'd82, 12'd16, 1'b0);
      bus.hit = 1'b1;
      tick(1);
      bus.hit = 1'b0;
      chk("s2_re_hit_on", 32'(bus.on_out), 32'd0);
      tick(7);
      launch("s2_low", 12'd0, 12'd50, 12'd22, 1'b0);
      tick(1);
      chk("s2_low_on", 32'(bus.on_out), 32'd0);
      chk("s2_low_y", 32'(bus.ypos_out), 32'd50);
      tick(7);

      // 4: held button gives one missile only; hit in IDLE has no effect
      launch("s4", 12'd300, 12'd400, 12'd322, 1'b1);
      tick(1);
      bus.hit = 1'b1;
      tick(1);
      bus.hit = 1'b0;
      chk("s4_hit_on", 32'(bus.on_out), 32'd0);
      tick(6);
      for (int i = 0; i < 4; i++) begin
         tick(1);
         chk("s4_held_on", 32'(bus.on_out), 32'd0);
         chk("s4_held_shot", 32'(bus.shot_fired), 32'd0);
      end
      bus.fire_button = 1'b0;
      tick(1);
      bus.hit = 1'b1;
      tick(2);
      bus.hit = 1'b0;
      chk("s4_idle_hit_on", 32'(bus.on_out), 32'd0);
      chk("s4_idle_hit_x", 32'(bus.xpos_out), 32'd322);
      chk("s4_idle_hit_y", 32'(bus.ypos_out), 32'd400);
      launch("s4_re", 12'd5, 12'd700, 12'd27, 1'b0);

      // 6: async reset mid-flight, button held through release
      tick(2);
      #3;
      rst_n = 1'b0;
      #1;
      chk("s6_rst_on", 32'(bus.on_out), 32'd0);
      chk("s6_rst_x", 32'(bus.xpos_out), 32'd0);
      chk("s6_rst_y", 32'(bus.ypos_out), 32'd0);
      chk("s6_rst_shot", 32'(bus.shot_fired), 32'd0);
      bus.fire_button = 1'b1;
      tick(2);
      #3;
      rst_n = 1'b1;
      tick(4);
      chk("s6_held_on", 32'(bus.on_out), 32'd0);
      chk("s6_held_shot", 32'(bus.shot_fired), 32'd0);
      bus.fire_button = 1'b0;
      tick(1);
      launch("s6_re", 12'd1, 12'd200, 12'd23, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
